// File: rtl/and_pulse_meas.sv
// Measures each high run of din in clk samples and queues {len, sat} records in a small FIFO.
// Optional drop accounting (drop_cnt, overflow) is enabled by defining AND_PULSE_MEAS_DROP_CNT_EN.
module and_pulse_meas #(
    parameter int CNT_W = 8,
    parameter int DEPTH = 4,
    parameter int TOT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [CNT_W-1:0] m_len,
    output logic             m_sat,
    output logic             run_active,
    output logic [TOT_W-1:0] pulse_total,
    output logic             full
`ifdef AND_PULSE_MEAS_DROP_CNT_EN
    ,
    output logic [7:0]       drop_cnt,
    output logic             overflow
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic IDLE = 1'b0;
    localparam logic RUN  = 1'b1;
    localparam logic [CNT_W-1:0] LEN_MAX = '1;

    logic             state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             sat_q, sat_d;
    logic [TOT_W-1:0] total_q, total_d;
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] len_mem_q [DEPTH];
    logic             sat_mem_q [DEPTH];

    logic push, pop, wr_en, empty;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        sat_d   = sat_q;
        total_d = total_q;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (din) begin
                    state_d = RUN;
                    len_d   = CNT_W'(1);
                    sat_d   = (CNT_W'(1) == LEN_MAX);
                end
            end
            RUN: begin
                if (din) begin
                    if (len_q != LEN_MAX) begin
                        len_d = len_q + CNT_W'(1);
                    end
                    sat_d = (len_d == LEN_MAX);
                end else begin
                    state_d = IDLE;
                    push    = 1'b1;
                    total_d = total_q + TOT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Same-edge pop frees the slot, so a push while full still lands when the head leaves.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop   = ~empty & m_ready;
    assign wr_en = push & (~full | pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (pop)   rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            len_q    <= '0;
            sat_q    <= 1'b0;
            total_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            sat_q    <= sat_d;
            total_q  <= total_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            len_mem_q[wr_ptr_q[AW-1:0]] <= len_q;
            sat_mem_q[wr_ptr_q[AW-1:0]] <= sat_q;
        end
    end

    assign m_valid     = ~empty;
    assign m_len       = empty ? '0 : len_mem_q[rd_ptr_q[AW-1:0]];
    assign m_sat       = empty ? 1'b0 : sat_mem_q[rd_ptr_q[AW-1:0]];
    assign run_active  = (state_q == RUN);
    assign pulse_total = total_q;

`ifdef AND_PULSE_MEAS_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;
    logic       ovf_q, ovf_d;
    logic       drop;

    assign drop = push & full & ~pop;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        ovf_d      = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
            if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
    assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_and_pulse_meas.sv
// Scoreboard bench for and_pulse_meas: a posedge model queues expected records, a negedge monitor checks them.
module tb_and_pulse_meas;
    localparam int CNT_W = 4;
    localparam int DEPTH = 4;
    localparam int TOT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             din = 1'b1;
    logic             m_ready = 1'b0;
    logic             m_valid;
    logic [CNT_W-1:0] m_len;
    logic             m_sat;
    logic             run_active;
    logic [TOT_W-1:0] pulse_total;
    logic             full;
`ifdef AND_PULSE_MEAS_DROP_CNT_EN
    logic [7:0]       drop_cnt;
    logic             overflow;
`endif

    and_pulse_meas #(.CNT_W(CNT_W), .DEPTH(DEPTH), .TOT_W(TOT_W)) dut (
        .clk(clk), .rst(rst), .din(din),
        .m_valid(m_valid), .m_ready(m_ready), .m_len(m_len), .m_sat(m_sat),
        .run_active(run_active), .pulse_total(pulse_total), .full(full)
`ifdef AND_PULSE_MEAS_DROP_CNT_EN
        , .drop_cnt(drop_cnt), .overflow(overflow)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CNT_W-1:0] len;
        logic             sat;
    } rec_t;

    rec_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_en   = 1'b0;
    bit   m_in_run = 1'b0;
    bit   m_pop;
    int   m_len_cnt = 0;
    int   m_occ = 0;
    int   m_total = 0;
    int   m_drops = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: builds expected records from the stimulus alone.
    initial forever begin
        rec_t r;
        @(posedge clk);
        if (rst) begin
            m_in_run  = 1'b0;
            m_len_cnt = 0;
            m_occ     = 0;
            m_total   = 0;
            m_drops   = 0;
            exp_q.delete();
        end else begin
            m_pop = (m_occ > 0) && m_ready;
            if (din) begin
                if (!m_in_run) m_len_cnt = 1;
                else if (m_len_cnt < 15) m_len_cnt++;
                m_in_run = 1'b1;
            end else if (m_in_run) begin
                m_in_run = 1'b0;
                m_total  = (m_total + 1) % 65536;
                if (m_occ < DEPTH || m_pop) begin
                    r.len = CNT_W'(m_len_cnt);
                    r.sat = (m_len_cnt == 15);
                    exp_q.push_back(r);
                    m_occ++;
                end else begin
                    m_drops++;
                end
            end
            if (m_pop) m_occ--;
        end
    end

    // Monitor: compares DUT outputs against the scoreboard away from the active edge.
    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            check("m_valid", 32'(m_valid), 32'(exp_q.size() != 0));
            check("full", 32'(full), 32'(m_occ == DEPTH));
            check("run_active", 32'(run_active), 32'(m_in_run));
            check("pulse_total", 32'(pulse_total), 32'(m_total));
            if (m_valid && exp_q.size() > 0) begin
                check("m_len", 32'(m_len), 32'(exp_q[0].len));
                check("m_sat", 32'(m_sat), 32'(exp_q[0].sat));
                if (m_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic cyc(input logic d, input logic r, input int n);
        din     = d;
        m_ready = r;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int act_cnt;

        // 1: reset with din high, run continues after release
        cyc(1'b1, 1'b0, 2);
        check("reset_m_valid", 32'(m_valid), 32'd0);
        check("reset_total", 32'(pulse_total), 32'd0);
        mon_en = 1'b1;
        rst = 1'b0;
        cyc(1'b1, 1'b0, 4);
        check("t1_run_active", 32'(run_active), 32'd1);
        check("t1_valid_before", 32'(m_valid), 32'd0);
        cyc(1'b0, 1'b0, 1);
        check("t1_valid_after", 32'(m_valid), 32'd1);
        check("t1_len", 32'(m_len), 32'd4);
        check("t1_sat", 32'(m_sat), 32'd0);
        check("t1_total", 32'(pulse_total), 32'd1);
        cyc(1'b0, 1'b1, 1);
        check("t1_drained", 32'(m_valid), 32'd0);

        // 2: three queued pulses of lengths 1,2,3
        cyc(1'b1, 1'b0, 1); cyc(1'b0, 1'b0, 2);
        cyc(1'b1, 1'b0, 2); cyc(1'b0, 1'b0, 2);
        cyc(1'b1, 1'b0, 3); cyc(1'b0, 1'b0, 2);
        check("t2_head", 32'(m_len), 32'd1);
        check("t2_full", 32'(full), 32'd0);
        check("t2_total", 32'(pulse_total), 32'd4);
        cyc(1'b0, 1'b1, 3);
        check("t2_empty", 32'(m_valid), 32'd0);

        // 3: saturation with CNT_W=4
        act_cnt = 0;
        din = 1'b1;
        m_ready = 1'b0;
        for (int i = 0; i < 23; i++) begin
            if (i == 20) din = 1'b0;
            @(posedge clk);
            #1;
            if (run_active) act_cnt++;
        end
        check("t3_active_cycles", 32'(act_cnt), 32'd20);
        check("t3_len", 32'(m_len), 32'd15);
        check("t3_sat", 32'(m_sat), 32'd1);
        cyc(1'b0, 1'b1, 1);

        // 4: overflow by six single-cycle pulses
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 1'b0, 1);
            cyc(1'b0, 1'b0, 1);
            if (i == 2) check("t4_not_full", 32'(full), 32'd0);
            if (i == 3) check("t4_full", 32'(full), 32'd1);
        end
        check("t4_total", 32'(pulse_total), 32'd6);
        check("t4_head", 32'(m_len), 32'd1);
`ifdef AND_PULSE_MEAS_DROP_CNT_EN
        check("t4_drop_cnt", 32'(drop_cnt), 32'd2);
        check("t4_overflow", 32'(overflow), 32'd1);
`endif

        // 5: push and pop on the same edge while full
        cyc(1'b1, 1'b0, 2);
        cyc(1'b0, 1'b1, 1);
        m_ready = 1'b0;
        check("t5_full", 32'(full), 32'd1);
        check("t5_total", 32'(pulse_total), 32'd7);
        cyc(1'b0, 1'b1, 3);
        check("t5_tail", 32'(m_len), 32'd2);
        cyc(1'b0, 1'b1, 1);
        check("t5_empty", 32'(m_valid), 32'd0);
`ifdef AND_PULSE_MEAS_DROP_CNT_EN
        check("t5_drop_cnt", 32'(drop_cnt), 32'd2);
`endif

        // 6: reset mid-run discards the partial run
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1);
        rst = 1'b0;
        cyc(1'b1, 1'b0, 5);
        rst = 1'b1;
        cyc(1'b1, 1'b0, 1);
        rst = 1'b0;
        cyc(1'b0, 1'b0, 3);
        check("t6_valid", 32'(m_valid), 32'd0);
        check("t6_total", 32'(pulse_total), 32'd0);
        check("t6_run_active", 32'(run_active), 32'd0);
`ifdef AND_PULSE_MEAS_DROP_CNT_EN
        check("t6_drop_cnt", 32'(drop_cnt), 32'd0);
        check("t6_overflow", 32'(overflow), 32'd0);
`endif
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
